// File: rtl/math_adder_digit_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit a+b+ci or a-b-ci, DIGIT bits per clock, LSB first.
// Optional clamp of s on signed overflow when MATH_ADDER_SATURATE_EN is defined.
module math_adder_digit_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("math_adder_digit_serial: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0]       a_sh, b_sh, s_work;
    logic                   carry;
    logic [CW-1:0]          cnt;
    logic                   load, last;
    logic [DIGIT-1:0]       sum_d;
    logic                   cy, cin_msb, cout, ov_raw;
    logic [WIDTH+DIGIT-1:0] shifted;
    logic [WIDTH-1:0]       s_next, s_fin;

    // Ripple chain over the current digit; cin_msb ends as the carry into the top bit of the digit.
    always_comb begin
        cy      = carry;
        cin_msb = carry;
        sum_d   = '0;
        for (int i = 0; i < DIGIT; i++) begin
            cin_msb  = cy;
            sum_d[i] = a_sh[i] ^ b_sh[i] ^ cy;
            cy       = (a_sh[i] & b_sh[i]) | (cy & (a_sh[i] ^ b_sh[i]));
        end
        cout = cy;
    end

    assign shifted = {sum_d, s_work};
    assign s_next  = shifted[WIDTH+DIGIT-1:DIGIT];
    assign ov_raw  = cin_msb ^ cout;
    assign last    = (cnt == CW'(N - 1));

`ifdef MATH_ADDER_SATURATE_EN
    // On overflow the true sign is the inverse of the wrapped MSB.
    always_comb begin
        s_fin = s_next;
        if (ov_raw) begin
            s_fin            = {WIDTH{s_next[WIDTH-1]}};
            s_fin[WIDTH-1]   = ~s_next[WIDTH-1];
        end
    end
`else
    assign s_fin = s_next;
`endif

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            s_work <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            co     <= 1'b0;
            ov     <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                a_sh  <= a;
                b_sh  <= b ^ {WIDTH{sub}};
                carry <= ci ^ sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> DIGIT;
                b_sh   <= b_sh >> DIGIT;
                carry  <= cout;
                s_work <= s_next;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    s  <= s_fin;
                    co <= cout;
                    ov <= ov_raw;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_math_adder_digit_serial.sv
// Bench for math_adder_digit_serial: WIDTH=8 with DIGIT=2 (main), DIGIT=8 and DIGIT=1 instances.
// Expected saturated values apply when MATH_ADDER_SATURATE_EN is defined.
module tb_math_adder_digit_serial;
    logic       clk = 1'b0;
    logic       rst;
    logic       sub, ci;
    logic [7:0] a, b;
    logic       start_v [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       co_v    [3];
    logic       ov_v    [3];
    logic [7:0] s_v     [3];
    int         checks = 0;
    int         errors = 0;
    localparam int LAT [3] = '{4, 1, 8};

    always #5 clk = ~clk;

    math_adder_digit_serial #(.WIDTH(8), .DIGIT(2)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .co(co_v[0]), .ov(ov_v[0]));
    math_adder_digit_serial #(.WIDTH(8), .DIGIT(8)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .co(co_v[1]), .ov(ov_v[1]));
    math_adder_digit_serial #(.WIDTH(8), .DIGIT(1)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .co(co_v[2]), .ov(ov_v[2]));

    function automatic void model(input logic sb, input logic [7:0] x, input logic [7:0] y,
                                  input logic c, output logic [7:0] r, output logic co_e,
                                  output logic ov_e);
        logic [8:0] t;
        if (!sb) begin
            t    = {1'b0, x} + {1'b0, y} + {8'd0, c};
            co_e = t[8];
            ov_e = (x[7] == y[7]) && (t[7] != x[7]);
        end else begin
            t    = {1'b0, x} - {1'b0, y} - {8'd0, c};
            co_e = ~t[8];
            ov_e = (x[7] != y[7]) && (t[7] != x[7]);
        end
        r = t[7:0];
`ifdef MATH_ADDER_SATURATE_EN
        if (ov_e) r = t[7] ? 8'h7F : 8'h80;
`endif
    endfunction

    // Counts rising edges until done is seen (sampled 1 time unit after the edge); -1 on timeout.
    task automatic wait_done(input int which, output int k, output int busy_n);
        k      = -1;
        busy_n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done_v[which]) begin
                k = i;
                break;
            end
            if (busy_v[which]) busy_n++;
        end
    endtask

    task automatic do_op(input int which, input logic sb, input logic [7:0] x, input logic [7:0] y,
                         input logic c, output logic [7:0] r, output logic co_o, output logic ov_o,
                         output int lat, output int busy_n, output bit held);
        logic [7:0] prev;
        int         bn;
        @(negedge clk);
        sub = sb; a = x; b = y; ci = c;
        start_v[which] = 1'b1;
        prev = s_v[which];
        @(posedge clk);
        #1;
        start_v[which] = 1'b0;
        a = ~x; b = ~y; ci = ~c; sub = ~sb;
        busy_n = busy_v[which] ? 1 : 0;
        held   = 1'b1;
        lat    = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1 && s_v[which] !== prev) held = 1'b0;
            @(posedge clk);
            #1;
            if (done_v[which]) begin
                lat = i;
                break;
            end
            if (busy_v[which]) busy_n++;
        end
        bn     = busy_n;
        busy_n = bn;
        r    = s_v[which];
        co_o = co_v[which];
        ov_o = ov_v[which];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (busy_v[w] !== 1'b0 || done_v[w] !== 1'b0 || s_v[w] !== 8'h00 ||
                co_v[w] !== 1'b0 || ov_v[w] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: busy=%b done=%b s=%h co=%b ov=%b, want all 0",
                         w, busy_v[w], done_v[w], s_v[w], co_v[w], ov_v[w]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        logic [7:0] r; logic c, o; int lat, bn; bit held;
        logic [7:0] exp_s;
`ifdef MATH_ADDER_SATURATE_EN
        exp_s = 8'h7F;
`else
        exp_s = 8'h80;
`endif
        do_op(0, 1'b0, 8'h7F, 8'h01, 1'b0, r, c, o, lat, bn, held);
        checks++;
        if (r !== exp_s || c !== 1'b0 || o !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf: s=%h co=%b ov=%b, want s=%h co=0 ov=1", r, c, o, exp_s);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL add_ovf_latency: got %0d, want 4", lat);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL add_ovf_hold: s changed before done");
        end
    endtask

    task automatic test_add_carry();
        logic [7:0] r; logic c, o; int lat, bn; bit held;
        do_op(0, 1'b0, 8'hFF, 8'h01, 1'b1, r, c, o, lat, bn, held);
        checks++;
        if (r !== 8'h01 || c !== 1'b1 || o !== 1'b0) begin
            errors++;
            $display("FAIL add_carry: s=%h co=%b ov=%b, want s=01 co=1 ov=0", r, c, o);
        end
        checks++;
        if (bn !== 4 || lat !== 4) begin
            errors++;
            $display("FAIL add_carry_busy: busy cycles=%0d latency=%0d, want 4 and 4", bn, lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_v[0] !== 1'b0 || s_v[0] !== 8'h01) begin
            errors++;
            $display("FAIL done_pulse: done=%b s=%h one cycle later, want done=0 s=01", done_v[0], s_v[0]);
        end
    endtask

    task automatic test_sub();
        logic [7:0] r; logic c, o; int lat, bn; bit held;
        logic [7:0] exp_s;
        do_op(0, 1'b1, 8'h10, 8'h20, 1'b0, r, c, o, lat, bn, held);
        checks++;
        if (r !== 8'hF0 || c !== 1'b0 || o !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: s=%h co=%b ov=%b, want s=f0 co=0 ov=0", r, c, o);
        end
`ifdef MATH_ADDER_SATURATE_EN
        exp_s = 8'h80;
`else
        exp_s = 8'h7F;
`endif
        do_op(0, 1'b1, 8'h80, 8'h01, 1'b0, r, c, o, lat, bn, held);
        checks++;
        if (r !== exp_s || c !== 1'b1 || o !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf: s=%h co=%b ov=%b, want s=%h co=1 ov=1", r, c, o, exp_s);
        end
        do_op(0, 1'b1, 8'h50, 8'h20, 1'b1, r, c, o, lat, bn, held);
        checks++;
        if (r !== 8'h2F || c !== 1'b1 || o !== 1'b0) begin
            errors++;
            $display("FAIL sub_ci: s=%h co=%b ov=%b, want s=2f co=1 ov=0", r, c, o);
        end
    endtask

    task automatic test_ignore_start();
        int k, bn;
        @(negedge clk);
        sub = 1'b0; a = 8'h21; b = 8'h13; ci = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        #1;
        a = 8'hAA; b = 8'h55; ci = 1'b1; sub = 1'b1;
        start_v[0] = 1'b1;
        wait_done(0, k, bn);
        start_v[0] = 1'b0;
        checks++;
        if (k !== 3 || s_v[0] !== 8'h34 || co_v[0] !== 1'b0 || ov_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: latency=%0d s=%h co=%b ov=%b, want latency 4 s=34 co=0 ov=0",
                     k + 1, s_v[0], co_v[0], ov_v[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL no_queue: busy=%b done=%b after done, want 0 0", busy_v[0], done_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        int k, bn;
        @(negedge clk);
        sub = 1'b0; a = 8'h05; b = 8'h03; ci = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, k, bn);
        checks++;
        if (k !== 4 || s_v[0] !== 8'h08) begin
            errors++;
            $display("FAIL b2b_first: latency=%0d s=%h, want 4 and 08", k, s_v[0]);
        end
        sub = 1'b1; a = 8'h20; b = 8'h0F; ci = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || s_v[0] !== 8'h08) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b s=%h, want busy=1 s=08", busy_v[0], s_v[0]);
        end
        wait_done(0, k, bn);
        checks++;
        if (k !== 4 || s_v[0] !== 8'h10 || co_v[0] !== 1'b1 || ov_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: latency=%0d s=%h co=%b ov=%b, want 4 10 1 0",
                     k, s_v[0], co_v[0], ov_v[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] r; logic c, o; int lat, bn; bit held;
        @(negedge clk);
        sub = 1'b0; a = 8'h33; b = 8'h44; ci = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || s_v[0] !== 8'h00 ||
            co_v[0] !== 1'b0 || ov_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b s=%h co=%b ov=%b, want all 0",
                     busy_v[0], done_v[0], s_v[0], co_v[0], ov_v[0]);
        end
        do_op(0, 1'b0, 8'h12, 8'h34, 1'b1, r, c, o, lat, bn, held);
        checks++;
        if (r !== 8'h47 || c !== 1'b0 || o !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL after_reset: s=%h co=%b ov=%b latency=%0d, want 47 0 0 4", r, c, o, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] r, x, y, es; logic c, o, sb, cc, ec, eo; int lat, bn; bit held;
        for (int w = 1; w < 3; w++) begin
            for (int i = 0; i < 1000; i++) begin
                x  = 8'($urandom_range(0, 255));
                y  = 8'($urandom_range(0, 255));
                sb = 1'($urandom_range(0, 1));
                cc = 1'($urandom_range(0, 1));
                model(sb, x, y, cc, es, ec, eo);
                do_op(w, sb, x, y, cc, r, c, o, lat, bn, held);
                checks++;
                if (r !== es || c !== ec || o !== eo || lat !== LAT[w] || !held) begin
                    errors++;
                    $display("FAIL random dut%0d sub=%b a=%h b=%h ci=%b: s=%h co=%b ov=%b lat=%0d held=%b, want s=%h co=%b ov=%b lat=%0d held=1",
                             w, sb, x, y, cc, r, c, o, lat, held, es, ec, eo, LAT[w]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        for (int w = 0; w < 3; w++) start_v[w] = 1'b0;
        test_reset();
        test_add_overflow();
        test_add_carry();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
